// File: rtl/ghost_reg_arbiter.sv
// Two-master round-robin arbiter in front of the ghost sprite register file slave port.
// Latency: write completes 1 cycle after the request is seen in IDLE, read 1+READ_LATENCY cycles after.
// Backpressure: the loser's WAITREQUEST stays high until it is served; every transaction ends with at least one IDLE cycle.
module ghost_reg_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        M0_READ,
    input  logic        M0_WRITE,
    input  logic [5:0]  M0_ADDR,
    input  logic [3:0]  M0_BYTE_EN,
    input  logic [31:0] M0_WRITEDATA,
    output logic [31:0] M0_READDATA,
    output logic        M0_WAITREQUEST,
    input  logic        M1_READ,
    input  logic        M1_WRITE,
    input  logic [5:0]  M1_ADDR,
    input  logic [3:0]  M1_BYTE_EN,
    input  logic [31:0] M1_WRITEDATA,
    output logic [31:0] M1_READDATA,
    output logic        M1_WAITREQUEST,
    output logic        AVL_CS,
    output logic        AVL_READ,
    output logic        AVL_WRITE,
    output logic [5:0]  AVL_ADDR,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [31:0] AVL_WRITEDATA,
    input  logic [31:0] AVL_READDATA,
    output logic [1:0]  GRANT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    // RDWAIT occupies READ_LATENCY-1 further cycles after ISSUE before completing.
    localparam logic [1:0] CNT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t      state_q;
    logic        win_q;      // owner of the current transaction (0 = M0, 1 = M1)
    logic        last_q;     // master granted most recently, loses the next tie
    logic        wr_q;
    logic [5:0]  addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic [31:0] cap_q;      // slave read data sampled on every edge
    logic [31:0] rd0_q;
    logic [31:0] rd1_q;

    logic        req0;
    logic        req1;
    logic        win_d;
    logic        done;
    logic        busy;
    logic [31:0] rdata_done;

    // Arbitration and completion decode from the registered state.
    always_comb begin
        req0  = M0_READ | M0_WRITE;
        req1  = M1_READ | M1_WRITE;
        // Sole requester wins; on a tie the master not granted last wins.
        win_d = req0 ? (req1 ? ~last_q : 1'b0) : 1'b1;
        busy  = (state_q != S_IDLE);
        done  = ((state_q == S_ISSUE) && (wr_q || (READ_LATENCY == 0))) ||
                ((state_q == S_RDWAIT) && (cnt_q == 2'd0));
        // Zero-latency reads have no earlier edge to sample on, so data passes straight through.
        rdata_done = (READ_LATENCY == 0) ? AVL_READDATA : cap_q;
    end

    // Transaction FSM: latch the winner's command in IDLE, strobe once, wait out the read latency.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            cap_q <= AVL_READDATA;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        win_q   <= win_d;
                        last_q  <= win_d;
                        // READ and WRITE together is treated as a write.
                        wr_q    <= win_d ? M1_WRITE     : M0_WRITE;
                        addr_q  <= win_d ? M1_ADDR      : M0_ADDR;
                        be_q    <= win_d ? M1_BYTE_EN   : M0_BYTE_EN;
                        wdata_q <= win_d ? M1_WRITEDATA : M0_WRITEDATA;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (done) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Read data is held per master until that master's next read completes.
            if (done && !wr_q) begin
                if (win_q) begin
                    rd1_q <= rdata_done;
                end else begin
                    rd0_q <= rdata_done;
                end
            end
        end
    end

    // Outputs decoded from registered state; all zero/idle whenever the FSM is in IDLE.
    always_comb begin
        BUSY           = busy;
        AVL_CS         = busy;
        AVL_READ       = busy && !wr_q;
        AVL_WRITE      = (state_q == S_ISSUE) && wr_q;
        AVL_ADDR       = busy ? addr_q : 6'd0;
        AVL_BYTE_EN    = busy ? be_q : 4'd0;
        AVL_WRITEDATA  = AVL_WRITE ? wdata_q : 32'd0;
        GRANT          = busy ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        M0_WAITREQUEST = !(done && !win_q);
        M1_WAITREQUEST = !(done && win_q);
        M0_READDATA    = (done && !wr_q && !win_q) ? rdata_done : rd0_q;
        M1_READDATA    = (done && !wr_q && win_q)  ? rdata_done : rd1_q;
    end

endmodule

// File: tb/tb_ghost_reg_arbiter.sv
// Bench for ghost_reg_arbiter: three instances at READ_LATENCY 1, 0 and 3 driven by
// directed and random master traffic, checked against a transaction-level model.
module tb_ghost_reg_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int a);
        if (a == 16) return 32'h00120034;
        return {8'(a), 8'hA5, 8'(a * 3), 8'h5A};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lb
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        logic        rst_n;
        logic        m_read [2];
        logic        m_write[2];
        logic [5:0]  m_addr [2];
        logic [3:0]  m_be   [2];
        logic [31:0] m_wdata[2];
        logic [31:0] m_rdata[2];
        logic        m_wait [2];
        logic        avl_cs, avl_read, avl_write;
        logic [5:0]  avl_addr;
        logic [3:0]  avl_be;
        logic [31:0] avl_wdata, avl_rdata;
        logic [1:0]  grant;
        logic        busy;
        logic [31:0] mem[64];
        logic        loaded = 1'b0;
        logic        fin = 1'b0;

        ghost_reg_arbiter #(.READ_LATENCY(LAT)) dut (
            .CLK(clk), .RESET(rst_n),
            .M0_READ(m_read[0]), .M0_WRITE(m_write[0]), .M0_ADDR(m_addr[0]),
            .M0_BYTE_EN(m_be[0]), .M0_WRITEDATA(m_wdata[0]),
            .M0_READDATA(m_rdata[0]), .M0_WAITREQUEST(m_wait[0]),
            .M1_READ(m_read[1]), .M1_WRITE(m_write[1]), .M1_ADDR(m_addr[1]),
            .M1_BYTE_EN(m_be[1]), .M1_WRITEDATA(m_wdata[1]),
            .M1_READDATA(m_rdata[1]), .M1_WAITREQUEST(m_wait[1]),
            .AVL_CS(avl_cs), .AVL_READ(avl_read), .AVL_WRITE(avl_write),
            .AVL_ADDR(avl_addr), .AVL_BYTE_EN(avl_be), .AVL_WRITEDATA(avl_wdata),
            .AVL_READDATA(avl_rdata), .GRANT(grant), .BUSY(busy)
        );

        // Slave register file: combinational read data while AVL_READ is high.
        assign avl_rdata = avl_read ? mem[avl_addr] : 32'h0;

        always @(negedge clk) begin
            if (!loaded) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
                loaded <= 1'b1;
            end else if (avl_write) begin
                for (int b = 0; b < 4; b++)
                    if (avl_be[b]) mem[avl_addr][8*b +: 8] <= avl_wdata[8*b +: 8];
            end
        end

        // Reference model state
        logic [31:0] ref_mem[64];
        int          last;
        logic [31:0] last_rd[2];
        bit          pend[2];
        bit          c_rd[2];
        bit          c_wr[2];
        logic [5:0]  c_addr[2];
        logic [3:0]  c_be[2];
        logic [31:0] c_wd[2];
        int          refill;

        function automatic string tg(input string s);
            return $sformatf("L%0d_%s", LAT, s);
        endfunction

        task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [5:0] a,
                               input logic [3:0] be, input logic [31:0] d);
            m_read[m] = rd; m_write[m] = wr; m_addr[m] = a; m_be[m] = be; m_wdata[m] = d;
            pend[m] = rd | wr; c_rd[m] = rd; c_wr[m] = wr;
            c_addr[m] = a; c_be[m] = be; c_wd[m] = d;
        endtask

        task automatic rand_cmd(input int m);
            int kind;
            kind = $urandom_range(0, 2);
            set_cmd(m, kind != 1, kind != 0, 6'($urandom_range(0, 63)), 4'($urandom), $urandom);
        endtask

        task automatic clr(input int m);
            m_read[m] = 1'b0; m_write[m] = 1'b0; pend[m] = 1'b0;
        endtask

        // Serve all pending requests; called at the negedge of an IDLE cycle with requests applied.
        task automatic serve();
            int w, o, ncyc;
            bit fin_cyc, rd_old, wr_old;
            logic [31:0] exp_rd;
            for (int guard = 0; guard < 64 && (pend[0] || pend[1]); guard++) begin
                w = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
                o = 1 - w;
                last = w;
                exp_rd = ref_mem[c_addr[w]];
                ncyc = c_wr[w] ? 1 : 1 + LAT;
                for (int k = 1; k <= ncyc; k++) begin
                    @(negedge clk);
                    fin_cyc = (k == ncyc);
                    chk(tg("grant"), 32'(grant), (w == 0) ? 32'd1 : 32'd2);
                    chk(tg("busy"), 32'(busy), 32'd1);
                    chk(tg("cs"), 32'(avl_cs), 32'd1);
                    chk(tg("avl_read"), 32'(avl_read), 32'(!c_wr[w]));
                    chk(tg("avl_write"), 32'(avl_write), 32'(c_wr[w] && k == 1));
                    chk(tg("avl_addr"), 32'(avl_addr), 32'(c_addr[w]));
                    chk(tg("avl_be"), 32'(avl_be), 32'(c_be[w]));
                    if (k == 1 && c_wr[w]) chk(tg("avl_wdata"), avl_wdata, c_wd[w]);
                    chk(tg("wait_win"), 32'(m_wait[w]), 32'(!fin_cyc));
                    chk(tg("wait_lose"), 32'(m_wait[o]), 32'd1);
                    chk(tg("rdata_lose"), m_rdata[o], last_rd[o]);
                    if (fin_cyc && !c_wr[w]) chk(tg("rdata_win"), m_rdata[w], exp_rd);
                end
                if (c_wr[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (c_be[w][b]) ref_mem[c_addr[w]][8*b +: 8] = c_wd[w][8*b +: 8];
                end else begin
                    last_rd[w] = exp_rd;
                end
                rd_old = c_rd[w];
                wr_old = c_wr[w];
                clr(w);
                if (refill > 0) begin
                    refill--;
                    set_cmd(w, rd_old, wr_old, 6'($urandom_range(0, 63)), 4'($urandom), $urandom);
                end
                @(negedge clk);
                chk(tg("idle_cs"), 32'(avl_cs), 32'd0);
                chk(tg("idle_strobes"), 32'({avl_read, avl_write}), 32'd0);
                chk(tg("idle_grant"), 32'(grant), 32'd0);
                chk(tg("idle_busy"), 32'(busy), 32'd0);
                chk(tg("idle_wait"), 32'({m_wait[0], m_wait[1]}), 32'd3);
                chk(tg("idle_rdata_hold"), m_rdata[w], last_rd[w]);
            end
        endtask

        initial begin
            rst_n = 1'b0;
            clr(0); clr(1);
            m_addr = '{6'd0, 6'd0}; m_be = '{4'd0, 4'd0}; m_wdata = '{32'd0, 32'd0};
            last = 1; last_rd = '{32'd0, 32'd0}; refill = 0;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

            // Request held during reset must not be granted.
            set_cmd(0, 1'b0, 1'b1, 6'h05, 4'hF, 32'hDEADBEEF);
            repeat (2) @(negedge clk);
            chk(tg("rst_wait"), 32'({m_wait[0], m_wait[1]}), 32'd3);
            chk(tg("rst_cs"), 32'(avl_cs), 32'd0);
            chk(tg("rst_grant"), 32'(grant), 32'd0);
            chk(tg("rst_busy"), 32'(busy), 32'd0);
            chk(tg("rst_rdata"), m_rdata[0] | m_rdata[1], 32'd0);
            rst_n = 1'b1;
            serve();

            // M1 read of the preloaded location.
            set_cmd(1, 1'b1, 1'b0, 6'h10, 4'hF, 32'h0);
            serve();
            chk(tg("m1_read_const"), m_rdata[1], 32'h00120034);

            // Continuous contention: M0 writes, M1 reads, six transactions.
            set_cmd(0, 1'b0, 1'b1, 6'h20, 4'hF, 32'h11112222);
            set_cmd(1, 1'b1, 1'b0, 6'h21, 4'hF, 32'h0);
            refill = 4;
            serve();

            // READ and WRITE together is a write; read it back through M1.
            set_cmd(0, 1'b1, 1'b1, 6'h02, 4'hF, 32'h0BADF00D);
            serve();
            set_cmd(1, 1'b1, 1'b0, 6'h02, 4'hF, 32'h0);
            serve();
            chk(tg("both_strobe_data"), m_rdata[1], 32'h0BADF00D);

            // Random traffic.
            repeat (30) begin
                int r;
                r = $urandom_range(1, 3);
                if (r[0]) rand_cmd(0);
                if (r[1]) rand_cmd(1);
                refill = $urandom_range(0, 2);
                serve();
            end

            // Reset in the middle of an M0 read.
            set_cmd(0, 1'b1, 1'b0, 6'h07, 4'hF, 32'h0);
            @(negedge clk);
            if (LAT > 0) @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk(tg("mid_rst_cs"), 32'(avl_cs), 32'd0);
            chk(tg("mid_rst_read"), 32'(avl_read), 32'd0);
            chk(tg("mid_rst_wait0"), 32'(m_wait[0]), 32'd1);
            chk(tg("mid_rst_grant"), 32'(grant), 32'd0);
            chk(tg("mid_rst_rdata"), m_rdata[0], 32'd0);
            clr(0);
            last = 1;
            last_rd = '{32'd0, 32'd0};
            @(negedge clk);
            chk(tg("mid_rst_busy"), 32'(busy), 32'd0);
            set_cmd(0, 1'b0, 1'b1, 6'h30, 4'h5, 32'hCAFEF00D);
            set_cmd(1, 1'b0, 1'b1, 6'h31, 4'hA, 32'h12345678);
            rst_n = 1'b1;
            serve();
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (lb[0].fin && lb[1].fin && lb[2].fin) break;
            @(posedge clk);
        end
        chk("all_done", 32'(lb[0].fin && lb[1].fin && lb[2].fin), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
